tns_dec_seq: RTL and testbench

- Parametrised, multi-cycle decoder for the tribonacci numeral system (TNS) used by the CAC link.
- Converts a CODE_W-bit TNS codeword into its DATA_W-bit binary value, processing DPC digits per clock, LSB-first.
- Digit weights are generated on the fly by a recurrence, so the block needs no per-width weight table.
- Sits at the receive side of the TSV bus, between the code sampler and the data sink; valid/ready handshake on both sides.

---
 rtl/tns_dec_seq_pkg.sv | 42 ++++
 rtl/tns_dec_seq_if.sv | 24 ++
 rtl/tns_weight_step.sv | 21 ++
 rtl/tns_dec_seq.sv | 168 ++++++++++++++++
 tb/tb_tns_dec_seq.sv | 283 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/tns_dec_seq_pkg.sv
// Shared definitions for the tribonacci-numeral decoder: defaults for the
// 19-digit CAC link, FSM state encoding, digit-weight and beat-count helpers.
package tns_dec_seq_pkg;

    localparam int CODE_W_DEF = 19;
    localparam int DATA_W_DEF = 18;
    localparam int DPC_DEF    = 4;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ACCUM = 2'd1,
        ST_DONE  = 2'd2
    } tns_state_e;

    // Weight of digit n: T(0)=1, T(1)=2, T(2)=4, T(n)=T(n-1)+T(n-2)+T(n-3).
    function automatic longint tns_weight(input int n);
        longint a;
        longint b;
        longint c;
        longint t;
        a = 64'sd1;
        b = 64'sd2;
        c = 64'sd4;
        for (int i = 0; i < n; i++) begin
            t = a + b + c;
            a = b;
            b = c;
            c = t;
        end
        return a;
    endfunction

    // Clock beats needed to consume code_w digits at dpc digits per beat.
    function automatic int tns_nbeats(input int code_w, input int dpc);
        if (dpc < 1) begin
            return 1;
        end else begin
            return (code_w + dpc - 1) / dpc;
        end
    endfunction

endpackage

// File: rtl/tns_dec_seq_if.sv
// Codeword-in / value-out handshake bundle of the TNS decoder.
// master = codeword source / result sink, slave = decoder.
interface tns_dec_seq_if #(
    parameter int CODE_W = tns_dec_seq_pkg::CODE_W_DEF,
    parameter int DATA_W = tns_dec_seq_pkg::DATA_W_DEF
) ();
    logic              in_valid;
    logic              in_ready;
    logic [CODE_W-1:0] codein;
    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] dataout;
    logic              ovf;

    modport master (
        output in_valid, codein, out_ready,
        input  in_ready, out_valid, dataout, ovf
    );

    modport slave (
        input  in_valid, codein, out_ready,
        output in_ready, out_valid, dataout, ovf
    );
endinterface

// File: rtl/tns_weight_step.sv
// One link of the weight recurrence: returns the weight of the current digit
// and advances the (wa,wb,wc) window by one digit position.
module tns_weight_step #(
    parameter int W = 19
) (
    input  logic [W-1:0] wa_i,
    input  logic [W-1:0] wb_i,
    input  logic [W-1:0] wc_i,
    output logic [W-1:0] w_use_o,
    output logic [W-1:0] wa_o,
    output logic [W-1:0] wb_o,
    output logic [W-1:0] wc_o
);
    // Slide the three-term window forward; wa is the weight of this digit.
    always_comb begin
        w_use_o = wa_i;
        wa_o    = wb_i;
        wb_o    = wc_i;
        wc_o    = wa_i + wb_i + wc_i;
    end
endmodule

// File: rtl/tns_dec_seq.sv
// Multi-cycle tribonacci-numeral decoder. Consumes DPC digits per clock,
// LSB first, generating digit weights on the fly with a chain of recurrence
// steps. Results are held in DONE until the sink accepts them.
module tns_dec_seq
    import tns_dec_seq_pkg::*;
#(
    parameter int CODE_W = CODE_W_DEF,
    parameter int DATA_W = DATA_W_DEF,
    parameter int DPC    = DPC_DEF
) (
    input  logic          clk,
    input  logic          rst_n,
    tns_dec_seq_if.slave  bus
);
    localparam int NBEATS = tns_nbeats(CODE_W, DPC);
    localparam int BEAT_W = (NBEATS > 1) ? $clog2(NBEATS) : 1;
    localparam int AW     = DATA_W + 1;
    localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(NBEATS - 1);

    if (CODE_W < 3 || DPC < 1 || DPC > CODE_W) begin : g_bad_params
        $error("tns_dec_seq: illegal CODE_W/DPC combination");
    end

    tns_state_e         state_q,     state_d;
    logic [CODE_W-1:0]  code_q,      code_d;
    logic [CODE_W-1:0]  mask_q,      mask_d;
    logic [AW-1:0]      acc_q,       acc_d;
    logic [AW-1:0]      wa_q,        wa_d;
    logic [AW-1:0]      wb_q,        wb_d;
    logic [AW-1:0]      wc_q,        wc_d;
    logic [BEAT_W-1:0]  beat_q,      beat_d;
    logic               ovf_run_q,   ovf_run_d;
    logic               in_ready_q,  in_ready_d;
    logic               out_valid_q, out_valid_d;
    logic [DATA_W-1:0]  dataout_q,   dataout_d;
    logic               ovf_q,       ovf_d;

    // Unrolled per-beat datapath: weight window and running sum per digit.
    logic [AW-1:0] wa_c  [DPC+1];
    logic [AW-1:0] wb_c  [DPC+1];
    logic [AW-1:0] wc_c  [DPC+1];
    logic [AW-1:0] acc_c [DPC+1];
    logic [AW-1:0] w_use_c [DPC];
    logic [DPC-1:0] ovf_c;

    assign wa_c[0]  = wa_q;
    assign wb_c[0]  = wb_q;
    assign wc_c[0]  = wc_q;
    assign acc_c[0] = acc_q;

    // mask_q marks digit positions that exist in the codeword, so digits past
    // CODE_W on a partial last beat neither add nor raise overflow.
    for (genvar g = 0; g < DPC; g++) begin : g_chain
        tns_weight_step #(.W(AW)) u_step (
            .wa_i    (wa_c[g]),
            .wb_i    (wb_c[g]),
            .wc_i    (wc_c[g]),
            .w_use_o (w_use_c[g]),
            .wa_o    (wa_c[g+1]),
            .wb_o    (wb_c[g+1]),
            .wc_o    (wc_c[g+1])
        );
        assign acc_c[g+1] = acc_c[g] + ((code_q[g] && mask_q[g]) ? w_use_c[g] : '0);
        assign ovf_c[g]   = mask_q[g] && (w_use_c[g][DATA_W] || acc_c[g+1][DATA_W]);
    end

    // Next-state and next-output logic for the IDLE/ACCUM/DONE sequencer.
    always_comb begin
        state_d     = state_q;
        code_d      = code_q;
        mask_d      = mask_q;
        acc_d       = acc_q;
        wa_d        = wa_q;
        wb_d        = wb_q;
        wc_d        = wc_q;
        beat_d      = beat_q;
        ovf_run_d   = ovf_run_q;
        out_valid_d = out_valid_q;
        dataout_d   = dataout_q;
        ovf_d       = ovf_q;
        case (state_q)
            ST_IDLE: begin
                if (bus.in_valid && in_ready_q) begin
                    code_d    = bus.codein;
                    mask_d    = {CODE_W{1'b1}};
                    acc_d     = '0;
                    wa_d      = AW'(1);
                    wb_d      = AW'(2);
                    wc_d      = AW'(4);
                    beat_d    = '0;
                    ovf_run_d = 1'b0;
                    state_d   = ST_ACCUM;
                end else begin
                    state_d   = ST_IDLE;
                end
            end
            ST_ACCUM: begin
                code_d    = code_q >> DPC;
                mask_d    = mask_q >> DPC;
                acc_d     = acc_c[DPC];
                wa_d      = wa_c[DPC];
                wb_d      = wb_c[DPC];
                wc_d      = wc_c[DPC];
                ovf_run_d = ovf_run_q | (|ovf_c);
                if (beat_q == LAST_BEAT) begin
                    dataout_d   = acc_c[DPC][DATA_W-1:0];
                    ovf_d       = ovf_run_q | (|ovf_c);
                    out_valid_d = 1'b1;
                    state_d     = ST_DONE;
                end else begin
                    beat_d      = beat_q + BEAT_W'(1);
                end
            end
            ST_DONE: begin
                if (bus.out_ready) begin
                    out_valid_d = 1'b0;
                    state_d     = ST_IDLE;
                end else begin
                    state_d     = ST_DONE;
                end
            end
            default: begin
                out_valid_d = 1'b0;
                state_d     = ST_IDLE;
            end
        endcase
        in_ready_d = (state_d == ST_IDLE);
    end

    // State and registered outputs; reset abandons any codeword in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            code_q      <= '0;
            mask_q      <= '0;
            acc_q       <= '0;
            wa_q        <= '0;
            wb_q        <= '0;
            wc_q        <= '0;
            beat_q      <= '0;
            ovf_run_q   <= 1'b0;
            in_ready_q  <= 1'b0;
            out_valid_q <= 1'b0;
            dataout_q   <= '0;
            ovf_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            code_q      <= code_d;
            mask_q      <= mask_d;
            acc_q       <= acc_d;
            wa_q        <= wa_d;
            wb_q        <= wb_d;
            wc_q        <= wc_d;
            beat_q      <= beat_d;
            ovf_run_q   <= ovf_run_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
            dataout_q   <= dataout_d;
            ovf_q       <= ovf_d;
        end
    end

    assign bus.in_ready  = in_ready_q;
    assign bus.out_valid = out_valid_q;
    assign bus.dataout   = dataout_q;
    assign bus.ovf       = ovf_q;

endmodule

// File: tb/tb_tns_dec_seq.sv
// Self-checking bench for tns_dec_seq: default build plus DPC=1, DPC=19 and
// DATA_W=17 builds, scoreboard-checked against the package weight model.
module tb_tns_dec_seq;
    import tns_dec_seq_pkg::*;

    typedef struct packed {
        logic [17:0] d;
        logic        o;
    } exp_t;

    logic clk;
    logic rst_n;
    int   n_checks;
    int   n_fail;
    exp_t exp_q[$];

    tns_dec_seq_if #(.CODE_W(19), .DATA_W(18)) m_if   ();
    tns_dec_seq_if #(.CODE_W(19), .DATA_W(18)) a1_if  ();
    tns_dec_seq_if #(.CODE_W(19), .DATA_W(18)) a19_if ();
    tns_dec_seq_if #(.CODE_W(19), .DATA_W(17)) a17_if ();

    tns_dec_seq #(.CODE_W(19), .DATA_W(18), .DPC(4))  u_main (.clk(clk), .rst_n(rst_n), .bus(m_if));
    tns_dec_seq #(.CODE_W(19), .DATA_W(18), .DPC(1))  u_d1   (.clk(clk), .rst_n(rst_n), .bus(a1_if));
    tns_dec_seq #(.CODE_W(19), .DATA_W(18), .DPC(19)) u_d19  (.clk(clk), .rst_n(rst_n), .bus(a19_if));
    tns_dec_seq #(.CODE_W(19), .DATA_W(17), .DPC(4))  u_w17  (.clk(clk), .rst_n(rst_n), .bus(a17_if));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Reference model for the 18-bit default build.
    function automatic exp_t model(input logic [18:0] code);
        longint s;
        exp_t   e;
        s = 64'sd0;
        for (int i = 0; i < 19; i++) begin
            if (code[i]) s += tns_weight(i);
        end
        e.d = s[17:0];
        e.o = (s >= 64'sd262144);
        return e;
    endfunction

    task automatic test_reset();
        rst_n = 1'b0;
        #12;
        n_checks += 4;
        if (m_if.in_ready !== 1'b0) begin n_fail++; $display("FAIL reset_in_ready got=%b exp=0", m_if.in_ready); end
        if (m_if.out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid got=%b exp=0", m_if.out_valid); end
        if (m_if.dataout !== 18'd0) begin n_fail++; $display("FAIL reset_dataout got=%0d exp=0", m_if.dataout); end
        if (m_if.ovf !== 1'b0) begin n_fail++; $display("FAIL reset_ovf got=%b exp=0", m_if.ovf); end
        rst_n = 1'b1;
        @(posedge clk); #1;
        n_checks++;
        if (m_if.in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_release_in_ready got=%b exp=1", m_if.in_ready); end
    endtask

    // One codeword through the default build, latency checked when asked.
    task automatic main_decode(input logic [18:0] code, input bit chk_lat, input string nm);
        int   cyc;
        int   lat;
        exp_t e;
        cyc = 0;
        while (!m_if.in_ready && cyc < 100) begin @(posedge clk); #1; cyc++; end
        m_if.in_valid = 1'b1;
        m_if.codein   = code;
        exp_q.push_back(model(code));
        @(posedge clk); #1;
        m_if.in_valid = 1'b0;
        lat = 0;
        while (!m_if.out_valid && lat < 100) begin @(posedge clk); #1; lat++; end
        e = exp_q.pop_front();
        n_checks += 2;
        if (m_if.dataout !== e.d) begin n_fail++; $display("FAIL %s_data got=%0d exp=%0d", nm, m_if.dataout, e.d); end
        if (m_if.ovf !== e.o) begin n_fail++; $display("FAIL %s_ovf got=%b exp=%b", nm, m_if.ovf, e.o); end
        if (chk_lat) begin
            n_checks++;
            if (lat != 5) begin n_fail++; $display("FAIL %s_latency got=%0d exp=5", nm, lat); end
        end
        m_if.out_ready = 1'b1;
        @(posedge clk); #1;
        m_if.out_ready = 1'b0;
    endtask

    task automatic test_basic();
        main_decode(19'h00001, 1'b1, "basic_1");
        main_decode(19'h00005, 1'b1, "basic_5");
        main_decode(19'h40000, 1'b1, "basic_bit18");
        main_decode(19'h7FFFF, 1'b1, "basic_all");
        main_decode(19'h00000, 1'b0, "basic_zero");
    endtask

    task automatic alt_get(input int which, output logic ov, output logic [17:0] d, output logic o);
        case (which)
            0: begin ov = a1_if.out_valid;  d = a1_if.dataout;          o = a1_if.ovf;  end
            1: begin ov = a19_if.out_valid; d = a19_if.dataout;         o = a19_if.ovf; end
            default: begin ov = a17_if.out_valid; d = {1'b0, a17_if.dataout}; o = a17_if.ovf; end
        endcase
    endtask

    task automatic alt_drive(input int which, input logic iv, input logic [18:0] code, input logic ordy);
        case (which)
            0: begin a1_if.in_valid = iv;  a1_if.codein = code;  a1_if.out_ready = ordy;  end
            1: begin a19_if.in_valid = iv; a19_if.codein = code; a19_if.out_ready = ordy; end
            default: begin a17_if.in_valid = iv; a17_if.codein = code; a17_if.out_ready = ordy; end
        endcase
    endtask

    task automatic run_alt(input int which, input logic [18:0] code, input int exp_lat,
                           input logic [17:0] exp_d, input logic exp_o, input string nm);
        int          lat;
        logic        ov;
        logic [17:0] d;
        logic        o;
        alt_drive(which, 1'b1, code, 1'b0);
        @(posedge clk); #1;
        alt_drive(which, 1'b0, code, 1'b0);
        lat = 0;
        alt_get(which, ov, d, o);
        while (!ov && lat < 64) begin @(posedge clk); #1; lat++; alt_get(which, ov, d, o); end
        n_checks += 3;
        if (lat != exp_lat) begin n_fail++; $display("FAIL %s_latency got=%0d exp=%0d", nm, lat, exp_lat); end
        if (d !== exp_d) begin n_fail++; $display("FAIL %s_data got=%0d exp=%0d", nm, d, exp_d); end
        if (o !== exp_o) begin n_fail++; $display("FAIL %s_ovf got=%b exp=%b", nm, o, exp_o); end
        alt_drive(which, 1'b0, code, 1'b1);
        @(posedge clk); #1;
        alt_drive(which, 1'b0, code, 1'b0);
    endtask

    task automatic test_params();
        run_alt(0, 19'h7FFFF, 19, 18'd144663, 1'b0, "dpc1_all");
        run_alt(1, 19'h7FFFF, 1,  18'd144663, 1'b0, "dpc19_all");
        run_alt(2, 19'h7FFFF, 5,  18'd13591,  1'b1, "w17_all");
        run_alt(1, 19'h00006, 1,  18'd6,      1'b0, "dpc19_6");
    endtask

    task automatic test_back_pressure();
        int   cyc;
        exp_t e;
        m_if.in_valid = 1'b1;
        m_if.codein   = 19'h12345;
        exp_q.push_back(model(19'h12345));
        @(posedge clk); #1;
        m_if.in_valid = 1'b0;
        cyc = 0;
        while (!m_if.out_valid && cyc < 100) begin @(posedge clk); #1; cyc++; end
        e = exp_q.pop_front();
        // Offer a second codeword while the result is stalled.
        m_if.in_valid = 1'b1;
        m_if.codein   = 19'h0ABCD;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
            n_checks += 3;
            if (m_if.dataout !== e.d || m_if.out_valid !== 1'b1) begin
                n_fail++; $display("FAIL bp_hold_%0d got=%0d/%b exp=%0d/1", i, m_if.dataout, m_if.out_valid, e.d);
            end
            if (m_if.in_ready !== 1'b0) begin n_fail++; $display("FAIL bp_in_ready_%0d got=%b exp=0", i, m_if.in_ready); end
            if (m_if.ovf !== e.o) begin n_fail++; $display("FAIL bp_ovf_%0d got=%b exp=%b", i, m_if.ovf, e.o); end
        end
        exp_q.push_back(model(19'h0ABCD));
        m_if.out_ready = 1'b1;
        @(posedge clk); #1;
        m_if.out_ready = 1'b0;
        n_checks++;
        if (m_if.out_valid !== 1'b0 || m_if.in_ready !== 1'b1) begin
            n_fail++; $display("FAIL bp_release got=%b/%b exp=0/1", m_if.out_valid, m_if.in_ready);
        end
        @(posedge clk); #1;
        m_if.in_valid = 1'b0;
        cyc = 0;
        while (!m_if.out_valid && cyc < 100) begin @(posedge clk); #1; cyc++; end
        e = exp_q.pop_front();
        n_checks++;
        if (m_if.dataout !== e.d) begin n_fail++; $display("FAIL bp_second_data got=%0d exp=%0d", m_if.dataout, e.d); end
        m_if.out_ready = 1'b1;
        @(posedge clk); #1;
        m_if.out_ready = 1'b0;
    endtask

    task automatic test_reset_mid();
        m_if.in_valid = 1'b1;
        m_if.codein   = 19'h7FFFF;
        @(posedge clk); #1;
        m_if.in_valid = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst_n = 1'b0;
        #1;
        n_checks += 4;
        if (m_if.out_valid !== 1'b0) begin n_fail++; $display("FAIL rmid_out_valid got=%b exp=0", m_if.out_valid); end
        if (m_if.dataout !== 18'd0) begin n_fail++; $display("FAIL rmid_dataout got=%0d exp=0", m_if.dataout); end
        if (m_if.ovf !== 1'b0) begin n_fail++; $display("FAIL rmid_ovf got=%b exp=0", m_if.ovf); end
        if (m_if.in_ready !== 1'b0) begin n_fail++; $display("FAIL rmid_in_ready got=%b exp=0", m_if.in_ready); end
        #3;
        rst_n = 1'b1;
        @(posedge clk); #1;
        main_decode(19'h00003, 1'b1, "rmid_after");
    endtask

    task automatic test_random();
        localparam int N = 30;
        fork
            begin : drv
                int          cyc;
                int          gap;
                logic [18:0] c;
                for (int k = 0; k < N; k++) begin
                    gap = $urandom_range(0, 3);
                    repeat (gap) begin @(posedge clk); #1; end
                    c = 19'($urandom);
                    m_if.in_valid = 1'b1;
                    m_if.codein   = c;
                    cyc = 0;
                    while (!m_if.in_ready && cyc < 300) begin @(posedge clk); #1; cyc++; end
                    if (cyc >= 300) begin
                        n_checks++; n_fail++;
                        $display("FAIL rand_accept_timeout item=%0d got=stall exp=accept", k);
                    end
                    exp_q.push_back(model(c));
                    @(posedge clk); #1;
                    m_if.in_valid = 1'b0;
                end
            end
            begin : mon
                int   cyc;
                int   rcv;
                exp_t e;
                cyc = 0;
                rcv = 0;
                while (rcv < N && cyc < 5000) begin
                    @(posedge clk); #1;
                    cyc++;
                    m_if.out_ready = 1'($urandom_range(0, 1));
                    if (m_if.out_valid && m_if.out_ready) begin
                        n_checks++;
                        if (exp_q.size() == 0) begin
                            n_fail++; $display("FAIL rand_extra got=%0d exp=none", m_if.dataout);
                        end else begin
                            e = exp_q.pop_front();
                            if (m_if.dataout !== e.d || m_if.ovf !== e.o) begin
                                n_fail++;
                                $display("FAIL rand_item_%0d got=%0d/%b exp=%0d/%b", rcv, m_if.dataout, m_if.ovf, e.d, e.o);
                            end
                        end
                        rcv++;
                    end
                end
                n_checks++;
                if (rcv != N) begin n_fail++; $display("FAIL rand_count got=%0d exp=%0d", rcv, N); end
            end
        join
        @(posedge clk); #1;
        m_if.out_ready = 1'b0;
        repeat (3) begin @(posedge clk); #1; end
        n_checks += 2;
        if (exp_q.size() != 0) begin n_fail++; $display("FAIL rand_leftover got=%0d exp=0", exp_q.size()); end
        if (m_if.out_valid !== 1'b0) begin n_fail++; $display("FAIL rand_duplicate got=%b exp=0", m_if.out_valid); end
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        rst_n    = 1'b0;
        m_if.in_valid = 1'b0; m_if.codein = '0; m_if.out_ready = 1'b0;
        alt_drive(0, 1'b0, 19'h0, 1'b0);
        alt_drive(1, 1'b0, 19'h0, 1'b0);
        alt_drive(2, 1'b0, 19'h0, 1'b0);
        test_reset();
        test_basic();
        test_params();
        test_back_pressure();
        test_reset_mid();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
